shift_serial_unit: RTL and testbench

Sequential, low-area counterpart to the combinational barrel shift unit in the ALU. It accepts the same operand encoding: `DATA1` is the value and `DATA2` carries `SHIFTOP` in `[7:6]` and the amount in `[3:0]`. It produces a bit-identical result by shifting one position per clock under a start/done handshake. It sits beside the ALU function units and is selected when a multi-cycle shift is acceptable in exchange for area.

---
 rtl/shift_serial_unit.sv | 110 +++++++++++
 tb/tb_shift_serial_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_serial_unit.sv
// rtl/shift_serial_unit.sv - multi-cycle 8-bit shifter/rotator, one bit position per clock
module shift_serial_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] work_q, work_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;

    // Command bits [5:4] carry no meaning for this unit.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^DATA2[5:4];

    // Rotation is periodic in 8; shifts saturate at 8 where the result stops changing.
    function automatic logic [3:0] eff_count(input logic [1:0] op, input logic [3:0] n);
        if (op == OP_ROR) begin
            return {1'b0, n[2:0]};
        end else if (n[3]) begin
            return 4'd8;
        end else begin
            return n;
        end
    endfunction

    // Single-position step; sra refills from bit 7, which never changes under sra.
    function automatic logic [7:0] shift_one(input logic [1:0] op, input logic [7:0] w);
        case (op)
            OP_SLL:  return {w[6:0], 1'b0};
            OP_SRL:  return {1'b0, w[7:1]};
            OP_SRA:  return {w[7], w[7:1]};
            default: return {w[0], w[7:1]};
        endcase
    endfunction

    // Next-state logic: capture in IDLE, step in SHIFT, publish result on the way to DONE.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    work_d  = DATA1;
                    op_d    = DATA2[7:6];
                    cnt_d   = eff_count(DATA2[7:6], DATA2[3:0]);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != 4'd0) begin
                    work_d = shift_one(op_q, work_q);
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    result_d = work_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            work_q   <= 8'h00;
            op_q     <= 2'b00;
            cnt_q    <= 4'd0;
            result_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_shift_serial_unit.sv
// tb/tb_shift_serial_unit.sv - directed self-checking bench for shift_serial_unit
module tb_shift_serial_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] last_result;

    shift_serial_unit dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .DATA1  (data1),
        .DATA2  (data2),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; sample k is taken after edge k.
    task automatic run_op(input string name, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] exp_r, input int ne);
        int done_cnt;
        int busy_cnt;
        int done_at;
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        start = 1'b1;
        data1 = d1;
        data2 = d2;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                data1 = ~d1;
                data2 = d2 ^ 8'hFF;
            end
            if (busy) busy_cnt++;
            if (k == ne) check({name, " result_hold"}, result, last_result);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    check({name, " result_at_done"}, result, exp_r);
                end
            end
        end
        check({name, " done_count"}, done_cnt, 1);
        check({name, " done_edge"}, done_at, ne + 1);
        check({name, " busy_cycles"}, busy_cnt, ne + 2);
        check({name, " result_final"}, result, exp_r);
        last_result = exp_r;
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int done_at;

        rst   = 1'b1;
        start = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;
        last_result = 8'h00;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("sll3",      8'h81, 8'h03, 8'h08, 3);
        run_op("srl2",      8'h81, 8'h42, 8'h20, 2);
        run_op("sra12",     8'h81, 8'h8C, 8'hFF, 8);
        run_op("ror9",      8'h81, 8'hC9, 8'hC0, 1);
        run_op("ror8",      8'h81, 8'hC8, 8'h81, 0);
        run_op("sll0_ign",  8'h5A, 8'h30, 8'h5A, 0);
        run_op("srl12",     8'h81, 8'h4C, 8'h00, 8);
        run_op("sll8",      8'hFF, 8'h08, 8'h00, 8);
        run_op("sra2_pos",  8'h70, 8'h82, 8'h1C, 2);
        run_op("ror3",      8'h81, 8'hC3, 8'h30, 3);

        // START pulses mid-SHIFT and in the DONE cycle must be ignored.
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        start = 1'b1;
        data1 = 8'h01;
        data2 = 8'h07;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 0) start = 1'b0;
            if (k == 3) begin
                start = 1'b1;
                data1 = 8'hFF;
                data2 = 8'h41;
            end
            if (k == 4) start = 1'b0;
            if (k == 8) begin
                start = 1'b1;
                data1 = 8'h33;
                data2 = 8'h01;
            end
            if (k == 9) start = 1'b0;
        end
        check("busyprot done_count", done_cnt, 1);
        check("busyprot done_edge", done_at, 8);
        check("busyprot busy_cycles", busy_cnt, 9);
        check("busyprot result", result, 8'h80);
        last_result = 8'h80;
        run_op("after_busyprot", 8'h0F, 8'h41, 8'h07, 1);

        // Reset after edge 3 of a long sra aborts it.
        start = 1'b1;
        data1 = 8'h80;
        data2 = 8'h88;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst result", result, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("midrst no_done", done_cnt, 0);
        check("midrst no_busy", busy_cnt, 0);
        check("midrst result_kept", result, 8'h00);
        last_result = 8'h00;
        run_op("after_rst", 8'h80, 8'h88, 8'hFF, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
